serial_subtractor: RTL



---
 rtl/serial_alu_pkg.sv | 22 ++
 rtl/fullAdder.sv | 21 ++
 rtl/serial_subtractor.sv | 113 +++++++++++
 3 files changed

// File: rtl/serial_alu_pkg.sv
// serial_alu_pkg: shared types for the bit-serial subtractor.
//   state_e  - control FSM states
//   flags_t  - ARM-style SUBS condition flags
//   DEF_WIDTH - default operand width
package serial_alu_pkg;

  localparam int DEF_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic negative;
    logic zero;
    logic carry;
    logic overflow;
  } flags_t;

endpackage

// File: rtl/fullAdder.sv
// fullAdder: gate-level one-bit full adder cell.
//   i_a, i_b, i_cin : addends and carry-in
//   o_s             : sum bit
//   o_co            : carry-out
module fullAdder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_co
);

  logic w_axb, w_gen, w_prop;

  xor u_x1 (w_axb, i_a, i_b);
  xor u_x2 (o_s, w_axb, i_cin);
  and u_a1 (w_gen, i_a, i_b);
  and u_a2 (w_prop, w_axb, i_cin);
  or  u_o1 (o_co, w_gen, w_prop);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial D = A - B, one bit per clock, LSB first,
// using a single full-adder cell fed with ~B and an initial carry of 1.
//   clk, rst_n : clock, async active-low reset
//   start      : request, accepted only in IDLE (A/B captured then)
//   busy       : high while shifting
//   done       : one-cycle pulse when D and flags are valid
//   D          : difference modulo 2^WIDTH
//   negative, zero, carry, overflow : SUBS flags (carry = NOT borrow)
module serial_subtractor
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             negative,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e           r_state, w_next;
  logic [WIDTH-1:0] r_ra, r_rb, r_rd;
  logic             r_c, r_nz, r_prev_c;
  logic [CW-1:0]    r_cnt;
  flags_t           r_flags;

  logic w_b_n, w_s, w_co, w_last, w_msb_in;

  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_msb_in = (r_cnt == CW'(WIDTH - 2));

  not u_inv (w_b_n, r_rb[0]);

  fullAdder u_fa (
    .i_a  (r_ra[0]),
    .i_b  (w_b_n),
    .i_cin(r_c),
    .o_s  (w_s),
    .o_co (w_co)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = SHIFT;
      SHIFT:   if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_ra     <= '0;
      r_rb     <= '0;
      r_rd     <= '0;
      r_c      <= 1'b0;
      r_nz     <= 1'b0;
      r_prev_c <= 1'b0;
      r_cnt    <= '0;
      r_flags  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (start) begin
          r_ra  <= A;
          r_rb  <= B;
          r_rd  <= '0;
          r_c   <= 1'b1;
          r_cnt <= '0;
          r_nz  <= 1'b0;
        end
        SHIFT: begin
          r_ra  <= {1'b0, r_ra[WIDTH-1:1]};
          r_rb  <= {1'b0, r_rb[WIDTH-1:1]};
          r_rd  <= {w_s, r_rd[WIDTH-1:1]};
          r_c   <= w_co;
          r_nz  <= r_nz | w_s;
          r_cnt <= r_cnt + 1'b1;
          if (w_msb_in) r_prev_c <= w_co;
          // Flags are latched on the final bit so they stay stable through
          // DONE and IDLE regardless of later datapath activity.
          if (w_last) begin
            r_flags.negative <= w_s;
            r_flags.zero     <= ~(r_nz | w_s);
            r_flags.carry    <= w_co;
            r_flags.overflow <= w_co ^ r_prev_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state == SHIFT);
  assign done     = (r_state == DONE);
  assign D        = r_rd;
  assign negative = r_flags.negative;
  assign zero     = r_flags.zero;
  assign carry    = r_flags.carry;
  assign overflow = r_flags.overflow;

endmodule
